// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
//   Request/response handshake bundle between an ALU client and alu_issue_ctrl.
//
//   Request channel  (client -> ctrl): req_valid, req_a, req_b, req_op,
//                                       req_setflags; req_ready back.
//   Response channel (ctrl -> client): rsp_valid, rsp_result, rsp_flags;
//                                       rsp_ready back.
//
//   master : the client issuing operations and consuming responses.
//   slave  : alu_issue_ctrl.
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        req_setflags;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;   // {N,Z,C,V}

  modport master (
    output req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_setflags, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of a 32-bit combinational ALU. Accepts one operation at a
//   time, drives registered operands/opcode to the ALU, captures the result and
//   N/Z/C/V into an architectural flag register, and returns them on a
//   response channel. Also sequences the ALU power domain: wake on demand,
//   isolate while unpowered or waking, power down after an idle timeout.
//
//   Ports:
//     clk, reset        : single clock; synchronous active-high reset
//     bus (slave)       : request/response handshake (alu_issue_ctrl_if)
//     alu_a/b/ctrl      : registered operands and opcode to the ALU
//     alu_result, alu_negative, alu_zero, alu_overflow, alu_cout : ALU outputs
//     flags             : architectural {N,Z,C,V}
//     alu_pwr_en        : ALU domain power enable
//     alu_iso           : ALU output isolation, active high
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned WAKE_CYCLES = 4,   // >= 1
  parameter int unsigned IDLE_CYCLES = 16,  // 0 disables power-down
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_ctrl_if.slave      bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [31:0]          alu_result,
  input  logic                 alu_negative,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 alu_cout,
  output logic [3:0]           flags,
  output logic                 alu_pwr_en,
  output logic                 alu_iso
);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam bit               IDLE_EN   = (IDLE_CYCLES != 0);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_READY,
    S_EXEC,
    S_HOLD,
    S_ISOLATE
  } state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;        // wake length / idle length
  logic              wake_pend_q, wake_pend_d;  // request seen while isolating
  logic [31:0]       a_q,         a_d;
  logic [31:0]       b_q,         b_d;
  logic [2:0]        ctrl_q,      ctrl_d;
  logic              setflags_q,  setflags_d;
  logic [31:0]       result_q,    result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [3:0]        flags_q,     flags_d;

  logic              pwr_en;
  logic              iso;
  logic              req_ready;
  logic [3:0]        next_flags;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wake_pend_d = wake_pend_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    setflags_d  = setflags_q;
    result_d    = result_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
    next_flags  = flags_q;
    pwr_en      = 1'b1;
    iso         = 1'b1;
    req_ready   = 1'b0;

    unique case (state_q)
      S_OFF: begin
        pwr_en = 1'b0;
        if (bus.req_valid || wake_pend_q) begin
          state_d     = S_WAKE;
          cnt_d       = '0;
          wake_pend_d = 1'b0;
        end
      end

      S_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_READY: begin
        iso       = 1'b0;
        req_ready = 1'b1;
        if (bus.req_valid) begin
          a_d        = bus.req_a;
          b_d        = bus.req_b;
          ctrl_d     = bus.req_op;
          setflags_d = bus.req_setflags;
          cnt_d      = '0;
          state_d    = S_EXEC;
        end else if (IDLE_EN) begin
          if (cnt_q == IDLE_LAST) begin
            state_d = S_ISOLATE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_EXEC: begin
        iso = 1'b0;
        // N/Z follow every op; C/V only mean something for ADD/SUB, and the
        // ALU's overflow output is undefined otherwise, so they are kept.
        if (setflags_q) begin
          next_flags[FLAG_N] = alu_negative;
          next_flags[FLAG_Z] = alu_zero;
          if (ctrl_q == OP_ADD || ctrl_q == OP_SUB) begin
            next_flags[FLAG_C] = alu_cout;
            next_flags[FLAG_V] = alu_overflow;
          end
        end
        result_d    = alu_result;
        rsp_flags_d = next_flags;
        flags_d     = next_flags;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        iso = 1'b0;
        if (bus.rsp_ready) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end

      S_ISOLATE: begin
        // The request is not taken here, but it is remembered so OFF turns
        // straight around into WAKE even if the requester drops valid.
        if (bus.req_valid) begin
          wake_pend_d = 1'b1;
        end
        state_d = S_OFF;
      end

      default: begin
        state_d = S_OFF;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      wake_pend_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      setflags_q  <= 1'b0;
      result_q    <= '0;
      rsp_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wake_pend_q <= wake_pend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      setflags_q  <= setflags_d;
      result_q    <= result_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_ctrl       = ctrl_q;
  assign flags          = flags_q;
  assign alu_pwr_en     = pwr_en;
  assign alu_iso        = iso;

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state_q == S_HOLD);
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. A behavioural ALU answers the DUT's
//   registered operands. Each issued op pushes its hand-computed expected
//   {result, flags} into a queue; an independent monitor pops and compares on
//   every response handshake. A second DUT built with IDLE_CYCLES=0 checks
//   that the domain never powers down.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();
  alu_issue_ctrl_if bus0 ();

  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_negative, alu_zero, alu_overflow, alu_cout;
  logic [3:0]  flags;
  logic        alu_pwr_en, alu_iso;

  logic [31:0] alu_a0, alu_b0;
  logic [2:0]  alu_ctrl0;
  logic [3:0]  flags0;
  logic        alu_pwr_en0, alu_iso0;

  alu_issue_ctrl #(.WAKE_CYCLES(4), .IDLE_CYCLES(16), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_cout     (alu_cout),
    .flags        (flags),
    .alu_pwr_en   (alu_pwr_en),
    .alu_iso      (alu_iso)
  );

  alu_issue_ctrl #(.WAKE_CYCLES(4), .IDLE_CYCLES(0), .CNT_W(8)) dut_noidle (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus0),
    .alu_a        (alu_a0),
    .alu_b        (alu_b0),
    .alu_ctrl     (alu_ctrl0),
    .alu_result   (32'h0),
    .alu_negative (1'b0),
    .alu_zero     (1'b1),
    .alu_overflow (1'b0),
    .alu_cout     (1'b0),
    .flags        (flags0),
    .alu_pwr_en   (alu_pwr_en0),
    .alu_iso      (alu_iso0)
  );

  // Behavioural ALU. Carry is bit 32 of the 33-bit result (for SUB that is the
  // borrow). For logic ops cout/overflow are undefined; they are driven high so
  // a controller that wrongly samples them gets caught.
  logic [32:0] sum_w, dif_w;
  always_comb begin
    sum_w        = {1'b0, alu_a} + {1'b0, alu_b};
    dif_w        = {1'b0, alu_a} - {1'b0, alu_b};
    alu_result   = '0;
    alu_cout     = 1'b1;
    alu_overflow = 1'b1;
    case (alu_ctrl)
      3'd0: alu_result = alu_a;
      3'd1: alu_result = alu_b;
      3'd2: begin
        alu_result   = sum_w[31:0];
        alu_cout     = sum_w[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum_w[31] != alu_a[31]);
      end
      3'd3: begin
        alu_result   = dif_w[31:0];
        alu_cout     = dif_w[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (dif_w[31] != alu_a[31]);
      end
      3'd4: alu_result = ~alu_a;
      3'd5: alu_result = alu_a & alu_b;
      3'd6: alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_negative = alu_result[31];
    alu_zero     = (alu_result == 32'h0);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];

  // Monitor: compares every response handshake against the queue head.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got response 0x%08h expected none",
                 bus.rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result", bus.rsp_result, e.res);
        check("rsp_flags",  32'(bus.rsp_flags), 32'(e.flg));
        check("flags_out",  32'(flags), 32'(e.flg));
      end
    end
  end

  // Drive a request and hold it until accepted. Called off the clock edge;
  // returns just after the accepting edge. wake_cnt counts cycles spent
  // powered but isolated before acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic sf,
                       input logic [31:0] exp_res, input logic [3:0] exp_flg,
                       output int wake_cnt);
    exp_t e;
    bit   got;
    e.res = exp_res;
    e.flg = exp_flg;
    sb.push_back(e);
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_op       = op;
    bus.req_setflags = sf;
    bus.req_valid    = 1'b1;
    wake_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      if (alu_pwr_en && alu_iso) wake_cnt++;
    end
    if (!got) fail_timeout("accept");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for a response handshake; returns just after the consuming edge.
  task automatic wait_rsp(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_timeout(name);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_state_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_state_flags"},     32'(flags), 32'd0);
    check({tag, "_state_pwr_en"},    32'(alu_pwr_en), 32'd0);
    check({tag, "_state_iso"},       32'(alu_iso), 32'd1);
  endtask

  task automatic no_rsp_window(input string name);
    int seen;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  wk;
    int  idle;
    bit  got;

    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.req_op        = '0;
    bus.req_setflags  = 1'b0;
    bus.rsp_ready     = 1'b1;
    bus0.req_valid    = 1'b0;
    bus0.req_a        = '0;
    bus0.req_b        = '0;
    bus0.req_op       = '0;
    bus0.req_setflags = 1'b0;
    bus0.rsp_ready    = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    check("reset_rsp_result", bus.rsp_result, 32'h0);
    check("reset_rsp_flags",  32'(bus.rsp_flags), 32'd0);
    check("reset_alu_a",      alu_a, 32'h0);
    check("reset_alu_b",      alu_b, 32'h0);
    check("reset_alu_ctrl",   32'(alu_ctrl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold start: ADD with signed overflow; WAKE lasts 4 cycles.
    issue(32'h7FFF_FFFF, 32'h1, 3'd2, 1'b1, 32'h8000_0000, 4'b1001, wk);
    check("wake_cycles", 32'(wk), 32'd4);
    wait_rsp("rsp_add_ovf");

    // SUB equal -> Z, then AND keeps C/V despite the ALU driving them high.
    issue(32'd5, 32'd5, 3'd3, 1'b1, 32'h0, 4'b0100, wk);
    check("ready_no_wake", 32'(wk), 32'd0);
    wait_rsp("rsp_sub_eq");
    issue(32'h0, 32'h0000_FFFF, 3'd5, 1'b1, 32'h0, 4'b0100, wk);
    wait_rsp("rsp_and");

    // ADD with carry, SUB with overflow, then ORR retaining C=0 / V=1.
    issue(32'hFFFF_FFFF, 32'h1, 3'd2, 1'b1, 32'h0, 4'b0110, wk);
    wait_rsp("rsp_add_carry");
    issue(32'h8000_0000, 32'h1, 3'd3, 1'b1, 32'h7FFF_FFFF, 4'b0001, wk);
    wait_rsp("rsp_sub_ovf");
    issue(32'h8000_0000, 32'h1, 3'd6, 1'b1, 32'h8000_0001, 4'b1001, wk);
    wait_rsp("rsp_orr");
    issue(32'd3, 32'd5, 3'd3, 1'b1, 32'hFFFF_FFFE, 4'b1010, wk);
    wait_rsp("rsp_sub_borrow");

    // XOR without setflags under response backpressure.
    bus.rsp_ready = 1'b0;
    issue(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd7, 1'b0, 32'hFFFF_FFFF, 4'b1010, wk);
    wait_rsp_valid("xor_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid",  32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_result", bus.rsp_result, 32'hFFFF_FFFF);
      check("hold_rsp_flags",  32'(bus.rsp_flags), 32'b1010);
      check("hold_req_ready",  32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_rsp("rsp_xor");

    // Idle timeout: 16 READY cycles, then one ISOLATE cycle.
    idle = 0;
    got  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (alu_iso) begin
        got = 1'b1;
        break;
      end
      if (bus.req_ready) idle++;
    end
    if (!got) fail_timeout("isolate");
    check("idle_cycles",     32'(idle), 32'd16);
    check("iso_pwr_en",      32'(alu_pwr_en), 32'd1);
    check("iso_req_ready",   32'(bus.req_ready), 32'd0);

    // Request raised during ISOLATE: OFF next cycle, WAKE the cycle after.
    begin
      exp_t e;
      e.res = 32'h1234_5678;
      e.flg = 4'b0010;
      sb.push_back(e);
    end
    bus.req_a        = 32'h1;
    bus.req_b        = 32'h1234_5678;
    bus.req_op       = 3'd1;
    bus.req_setflags = 1'b1;
    bus.req_valid    = 1'b1;
    @(negedge clk);
    check("off_pwr_en",    32'(alu_pwr_en), 32'd0);
    check("off_iso",       32'(alu_iso), 32'd1);
    check("off_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("rewake_pwr_en", 32'(alu_pwr_en), 32'd1);
    check("rewake_iso",    32'(alu_iso), 32'd1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_timeout("rewake_accept");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_rsp("rsp_after_isolate");

    // Reset while the op is in EXEC.
    issue(32'd1, 32'd1, 3'd2, 1'b1, 32'd2, 4'b0000, wk);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_state("exec_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    no_rsp_window("exec_rst_no_stale");

    // Reset while the response is held in HOLD.
    bus.rsp_ready = 1'b0;
    issue(32'd7, 32'd9, 3'd2, 1'b1, 32'd16, 4'b0000, wk);
    wait_rsp_valid("hold_rst_rsp_valid");
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_state("hold_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    no_rsp_window("hold_rst_no_stale");

    // Fresh op after reset: C/V start from zero again.
    issue(32'h0, 32'hDEAD_BEEF, 3'd0, 1'b1, 32'h0, 4'b0100, wk);
    check("wake_after_reset", 32'(wk), 32'd4);
    wait_rsp("rsp_after_reset");
    check("queue_drained", 32'(sb.size()), 32'd0);

    // IDLE_CYCLES=0 build: one op to wake it, then 100 idle cycles powered.
    bus0.req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus0.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_timeout("noidle_accept");
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle = 0;
    repeat (100) begin
      @(negedge clk);
      if (alu_pwr_en0 && bus0.req_ready && !alu_iso0) idle++;
    end
    check("noidle_powered_cycles", 32'(idle), 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 32-bit ALU interface. It accepts one operation at a time over a valid/ready request channel and drives registered A/B/ctrl to the combinational ALU. It captures the result and the N/Z/V/C flags into an architectural flag register and returns them over a valid/ready response channel. It also owns the ALU power domain: it wakes the domain on demand, isolates it, and powers it down after an idle timeout.

Parameters:
WAKE_CYCLES, 4, cycles alu_pwr_en is held with isolation on before the ALU is usable (must be >=1)
IDLE_CYCLES, 16, consecutive idle READY cycles before power-down; 0 = never power down
CNT_W, 8, width of wake/idle counter (must hold max(WAKE_CYCLES, IDLE_CYCLES))

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_a  in  32  operand A
req_b  in  32  operand B
req_op  in  3  ALU opcode: 0 BYPASSA, 1 BYPASSB, 2 ADD, 3 SUB, 4 NOT, 5 AND, 6 ORR, 7 XOR
req_setflags  in  1  update flag register with this op
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_ctrl  out  3  registered opcode to ALU
alu_result  in  32  ALU result
alu_negative  in  1  ALU N
alu_zero  in  1  ALU Z
alu_overflow  in  1  ALU V (valid only for ADD/SUB)
alu_cout  in  1  ALU carry-out (bit 32 of result)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_result  out  32  captured result
rsp_flags  out  4  {N,Z,C,V} flag register value after this op
flags  out  4  architectural {N,Z,C,V}, always visible
alu_pwr_en  out  1  ALU domain power enable
alu_iso  out  1  ALU output isolation, active high

Behaviour:
- Reset (sync, active-high; overrides everything, including mid-operation): state OFF, alu_pwr_en=0, alu_iso=1, req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, flags=0, alu_a/alu_b/alu_ctrl=0, counter=0. In-flight ops are dropped.
- States: OFF, WAKE, READY, EXEC, HOLD, ISOLATE.
- OFF: pwr_en=0, iso=1, req_ready=0. If req_valid: go to WAKE, counter=0.
- WAKE: pwr_en=1, iso=1, req_ready=0. Counter increments. After WAKE_CYCLES cycles in WAKE, go to READY with iso=0.
- READY: pwr_en=1, iso=0, req_ready=1. The only state with req_ready=1 (one op outstanding).
  - Accept: register req_a/b/op into alu_a/b/ctrl, latch setflags, clear idle counter, go to EXEC.
  - No req_valid: idle counter increments. When IDLE_CYCLES>0 and the count reaches IDLE_CYCLES, go to ISOLATE.
  - req_valid held low but present? It is sampled every cycle and any req_valid clears the idle counter.
- EXEC: the ALU evaluates the registered inputs. At the end of the cycle, capture rsp_result=alu_result and compute the new flags, then go to HOLD with rsp_valid=1.
- Flag update (only if setflags latched; otherwise flags unchanged and rsp_flags=current flags):
  - N and Z are updated for every op.
  - C=alu_cout and V=alu_overflow are updated only for ADD/SUB. Other ops retain C and V; alu_overflow is ignored because it is undefined.
- HOLD: rsp_valid=1, outputs stable until rsp_ready. On handshake, go to READY. The idle counter restarts at 0.
- ISOLATE: pwr_en=1, iso=1 for exactly 1 cycle, then OFF (pwr_en=0).
  - A req_valid seen during ISOLATE is not accepted. It causes OFF to go immediately to WAKE on the next cycle.
- Latency: accept at cycle N; EXEC at N+1; rsp_valid=1 at N+2. Maximum throughput is 1 op per 3 cycles with rsp_ready tied high.
- Power invariant: iso=1 whenever pwr_en=0 or the domain is not yet awake. alu_* inputs are never sampled unless the state is EXEC.

Test Plan:
- Reset then req ADD A=0x7FFFFFFF B=1 setflags=1 -> WAKE lasts 4 cycles, req_ready rises, rsp_result=0x80000000, rsp_flags N=1 Z=0 C=0 V=1, flags match.
- From READY, SUB A=5 B=5 setflags=1, then AND A=0 B=0xFFFF setflags=1 -> first op Z=1, C=0, V=0; second op N=0, Z=1, and C/V are retained from the SUB.
- XOR 0xF0F0F0F0^0x0F0F0F0F with setflags=0 -> rsp_result=0xFFFFFFFF, flags unchanged; hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_result and rsp_flags stay stable, req_ready=0.
- Idle 16 cycles in READY -> ISOLATE for 1 cycle (iso=1, pwr_en=1), then OFF (pwr_en=0); req_valid during ISOLATE -> not accepted, WAKE entered two cycles later, op completes correctly.
- Assert reset during EXEC and during HOLD -> next cycle state OFF, rsp_valid=0, flags=0, pwr_en=0, iso=1; no stale response appears afterward.
- IDLE_CYCLES=0 build: 100 idle cycles -> alu_pwr_en stays 1 and req_ready stays 1.
